// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_cfg
//  Purpose  : Parameterised UART transmitter. A request is accepted on the
//             edge where start=1 and ready=1. The frame is: one start bit (0),
//             DATA_BITS data bits LSB first, an optional parity bit, then
//             STOP_BITS stop bits (1). Each bit is held for CLK_DIV clk cycles.
//  Ports    : clk   - system clock, rising edge
//             rstn  - synchronous active-low reset
//             start - transmit request, qualified by ready
//             data  - word to send, latched at acceptance
//             tx    - registered serial line, idle high
//             ready - 1 while idle and able to accept a request
//             done  - one-cycle pulse on the edge the frame completes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLK_DIV   = 1250,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready,
    output logic                 done
);

    // Elaboration-time parameter checks
    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("uart_tx_cfg: CLK_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..8");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int               c_CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_MAX = c_CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       c_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       c_LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [c_CNT_W-1:0]   r_baud_cnt, w_baud_nxt;
    logic [2:0]           r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_par,      w_par_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_ready,    w_ready_nxt;
    logic                 r_done,     w_done_nxt;

    logic                 w_bit_end;
    logic                 w_par_bit;

    assign w_bit_end = (r_baud_cnt == c_BAUD_MAX);
    // Parity is computed from the incoming word so it is ready at acceptance
    assign w_par_bit = (PARITY == 2) ? ~(^data) : (^data);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                if (start && r_ready) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = data;
                    w_par_nxt   = w_par_bit;
                    w_tx_nxt    = 1'b0;   // start bit goes out on the acceptance edge
                    w_ready_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == c_LAST_DATA) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PAR;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == c_LAST_STOP) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                        w_tx_nxt    = 1'b1;
                        w_ready_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                // Unused encodings recover to idle
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_cfg
//  Purpose  : Directed self-checking bench for uart_tx_cfg. Four instances
//             cover 8N1 and 7E1/7O1 at CLK_DIV=4 and 8N2 at CLK_DIV=2.
//             Inputs are driven and outputs sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       clk;
    logic       rstn;
    logic [3:0] start_v;
    logic [7:0] data_v;
    logic [3:0] tx_v;
    logic [3:0] ready_v;
    logic [3:0] done_v;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rstn(rstn), .start(start_v[0]), .data(data_v),
        .tx(tx_v[0]), .ready(ready_v[0]), .done(done_v[0]));

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rstn(rstn), .start(start_v[1]), .data(data_v[6:0]),
        .tx(tx_v[1]), .ready(ready_v[1]), .done(done_v[1]));

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7o1 (
        .clk(clk), .rstn(rstn), .start(start_v[2]), .data(data_v[6:0]),
        .tx(tx_v[2]), .ready(ready_v[2]), .done(done_v[2]));

    uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rstn(rstn), .start(start_v[3]), .data(data_v),
        .tx(tx_v[3]), .ready(ready_v[3]), .done(done_v[3]));

    // Reset state of every instance, held and after release
    task automatic test_reset();
        rstn    = 1'b0;
        start_v = 4'h0;
        data_v  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_v !== 4'hF) begin errors++; $display("FAIL reset_tx got=%b exp=%b", tx_v, 4'hF); end
        checks++; if (ready_v !== 4'hF) begin errors++; $display("FAIL reset_ready got=%b exp=%b", ready_v, 4'hF); end
        checks++; if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done got=%b exp=%b", done_v, 4'h0); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx_v !== 4'hF) begin errors++; $display("FAIL post_reset_tx got=%b exp=%b", tx_v, 4'hF); end
        checks++; if (ready_v !== 4'hF) begin errors++; $display("FAIL post_reset_ready got=%b exp=%b", ready_v, 4'hF); end
        checks++; if (done_v !== 4'h0) begin errors++; $display("FAIL post_reset_done got=%b exp=%b", done_v, 4'h0); end
    endtask

    // One frame per format; k counts falling edges after the acceptance edge.
    // Data is scrambled right after acceptance to show it is latched.
    task automatic test_frame_formats();
        int         sel_t [4] = '{0, 1, 2, 3};
        logic [7:0] d_t   [4] = '{8'h55, 8'h03, 8'h03, 8'hA0};
        int         div_t [4] = '{4, 4, 4, 2};
        int         nb_t  [4] = '{10, 10, 10, 11};
        logic [11:0] exp_t[4] = '{12'h2AA, 12'h206, 12'h306, 12'h740};
        int   s, n_cyc;
        logic e_tx, e_rdy, e_done;
        for (int c = 0; c < 4; c++) begin
            s     = sel_t[c];
            n_cyc = div_t[c] * nb_t[c];
            @(negedge clk);
            data_v     = d_t[c];
            start_v[s] = 1'b1;
            @(posedge clk);
            #1;
            start_v[s] = 1'b0;
            data_v     = ~d_t[c];
            for (int k = 0; k <= n_cyc + 1; k++) begin
                @(negedge clk);
                if (k < n_cyc) begin
                    e_tx = exp_t[c][k / div_t[c]]; e_rdy = 1'b0; e_done = 1'b0;
                end else if (k == n_cyc) begin
                    e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b1;
                end else begin
                    e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
                end
                checks++; if (tx_v[s] !== e_tx) begin errors++; $display("FAIL fmt%0d_tx k=%0d got=%b exp=%b", c, k, tx_v[s], e_tx); end
                checks++; if (ready_v[s] !== e_rdy) begin errors++; $display("FAIL fmt%0d_ready k=%0d got=%b exp=%b", c, k, ready_v[s], e_rdy); end
                checks++; if (done_v[s] !== e_done) begin errors++; $display("FAIL fmt%0d_done k=%0d got=%b exp=%b", c, k, done_v[s], e_done); end
            end
        end
    endtask

    // A request for 0xFF arriving mid-frame is dropped, not queued
    task automatic test_ignore_busy();
        logic [11:0] f = 12'h200;
        logic e_tx, e_rdy, e_done;
        @(negedge clk);
        data_v     = 8'h00;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int k = 0; k <= 52; k++) begin
            @(negedge clk);
            if (k < 40) begin
                e_tx = f[k / 4]; e_rdy = 1'b0; e_done = 1'b0;
            end else if (k == 40) begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b1;
            end else begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
            end
            checks++; if (tx_v[0] !== e_tx) begin errors++; $display("FAIL busy_tx k=%0d got=%b exp=%b", k, tx_v[0], e_tx); end
            checks++; if (ready_v[0] !== e_rdy) begin errors++; $display("FAIL busy_ready k=%0d got=%b exp=%b", k, ready_v[0], e_rdy); end
            checks++; if (done_v[0] !== e_done) begin errors++; $display("FAIL busy_done k=%0d got=%b exp=%b", k, done_v[0], e_done); end
            if (k == 9) begin
                start_v[0] = 1'b1;
                data_v     = 8'hFF;
            end else if (k == 10) begin
                start_v[0] = 1'b0;
            end
        end
    endtask

    // start held high: 0x12 then 0x34 with exactly one idle cycle between
    task automatic test_back_to_back();
        logic [11:0] f1 = 12'h224;
        logic [11:0] f2 = 12'h268;
        logic e_tx, e_rdy, e_done;
        @(negedge clk);
        data_v     = 8'h12;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        data_v = 8'h34;
        for (int k = 0; k <= 85; k++) begin
            @(negedge clk);
            if (k < 40) begin
                e_tx = f1[k / 4]; e_rdy = 1'b0; e_done = 1'b0;
            end else if (k == 40 || k == 81) begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b1;
            end else if (k < 81) begin
                e_tx = f2[(k - 41) / 4]; e_rdy = 1'b0; e_done = 1'b0;
            end else begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
            end
            checks++; if (tx_v[0] !== e_tx) begin errors++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx_v[0], e_tx); end
            checks++; if (ready_v[0] !== e_rdy) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, ready_v[0], e_rdy); end
            checks++; if (done_v[0] !== e_done) begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done_v[0], e_done); end
            if (k == 41) start_v[0] = 1'b0;
        end
    endtask

    // Reset during data bit 3 abandons the frame; 0x81 then goes out cleanly
    task automatic test_reset_mid_frame();
        logic [11:0] f1 = 12'h2AA;
        logic [11:0] f2 = 12'h302;
        logic e_tx, e_rdy, e_done;
        @(negedge clk);
        data_v     = 8'h55;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            checks++; if (tx_v[0] !== f1[k / 4]) begin errors++; $display("FAIL rst_pre_tx k=%0d got=%b exp=%b", k, tx_v[0], f1[k / 4]); end
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got=%b exp=1", tx_v[0]); end
        checks++; if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready_v[0]); end
        checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done_v[0]); end
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL rst_after_done k=%0d got=%b exp=0", k, done_v[0]); end
            checks++; if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL rst_after_tx k=%0d got=%b exp=1", k, tx_v[0]); end
        end
        data_v     = 8'h81;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k < 40) begin
                e_tx = f2[k / 4]; e_rdy = 1'b0; e_done = 1'b0;
            end else if (k == 40) begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b1;
            end else begin
                e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
            end
            checks++; if (tx_v[0] !== e_tx) begin errors++; $display("FAIL rst_new_tx k=%0d got=%b exp=%b", k, tx_v[0], e_tx); end
            checks++; if (ready_v[0] !== e_rdy) begin errors++; $display("FAIL rst_new_ready k=%0d got=%b exp=%b", k, ready_v[0], e_rdy); end
            checks++; if (done_v[0] !== e_done) begin errors++; $display("FAIL rst_new_done k=%0d got=%b exp=%b", k, done_v[0], e_done); end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rstn    = 1'b0;
        start_v = 4'h0;
        data_v  = 8'h00;
        test_reset();
        test_frame_formats();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
